ysyx_24090013_regfile_sb: RTL

Parametrised multi-read-port general-purpose register file with a built-in scoreboard. It is the next generation of the core's register file. It adds the following over the current block:
- a reset-time clear sweep
- an optional hardwired-zero register
- optional write-to-read bypass
- per-register busy bits that let decode detect operands with an outstanding writeback

It sits between decode (reads, marks) and writeback (writes) in the NPC core.

---
 rtl/ysyx_24090013_regfile_sb.sv | 116 +++++++++++
 1 files changed

// File: rtl/ysyx_24090013_regfile_sb.sv
// Register file with a built-in scoreboard. After reset it zeroes every entry with a clear sweep.
// Reads are combinational, with optional write forwarding and a hardwired x0.
module ysyx_24090013_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_done,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD-1:0]            ren,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         mark_en,
  input  logic [ADDR_WIDTH-1:0]        mark_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  run;
  logic                  sweep;
  logic                  do_write;
  logic                  do_mark;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_ptr == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // rst gates the outputs directly so they are quiet in the reset cycle itself.
  always_comb begin
    run       = (state == RUN) && !rst;
    sweep     = (state == CLEAR) && !rst;
    init_done = run;
  end

  always_ff @(posedge clk) begin
    if (rst)        clr_ptr <= '0;
    else if (sweep) clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
  end

  assign do_write = run && wen && !is_zero(waddr);
  assign do_mark  = run && mark_en && !is_zero(mark_addr);

  // NOTE: the array has no reset branch; the clear sweep is what zeroes it, keeping it RAM-friendly.
  always_ff @(posedge clk) begin
    if (sweep)         rf[clr_ptr] <= '0;
    else if (do_write) rf[waddr]   <= wdata;
  end

  // Mark is applied after the write clear, so a same-index mark wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (do_write) busy[waddr]     <= 1'b0;
      if (do_mark)  busy[mark_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rb_val;

    assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_val = '0;
      rb_val = 1'b0;
      if (run && ren[i] && !is_zero(ra)) begin
        if ((BYPASS != 0) && wen && (waddr == ra)) begin
          rd_val = wdata;
        end else begin
          rd_val = rf[ra];
          rb_val = busy[ra];
        end
      end
    end

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd_val;
    assign rbusy[i]                          = rb_val;
  end

endmodule
